// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and the NOP word loaded by flushed registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    DMEM_WAIT,
    IMEM_WAIT
  } ctrl_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Shared by the perf counters and the wait watchdogs.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Turns hazard and memory-wait inputs into register enables and bubbles.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fwd_stall,
  input  logic             br_taken_EX,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_timeout
);

  localparam int WD_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

  ctrl_state_t state, state_nxt;
  logic kill, kill_nxt;
  logic sel_dm, sel_lu, sel_br, sel_im, sel_run;
  logic accept;
  logic [WD_W-1:0] iwd, dwd;

  assign sel_dm  = dmem_wait;
  assign sel_lu  = !sel_dm && fwd_stall
                && (state != LU_STALL);
  assign sel_br  = !sel_dm && !sel_lu
                && br_taken_EX;
  assign sel_im  = !sel_dm && !sel_lu
                && !sel_br && imem_wait;
  assign sel_run = !sel_dm && !sel_lu
                && !sel_br && !sel_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  always_comb begin
    state_nxt   = RUN;
    kill_nxt    = kill;
    accept      = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    pc_redirect = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (1'b1)
      sel_dm: begin
        state_nxt = DMEM_WAIT;
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
      end
      sel_lu: begin
        state_nxt   = LU_STALL;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end
      sel_br: begin
        accept      = 1'b1;
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        kill_nxt    = imem_wait;
      end
      sel_im: begin
        state_nxt  = IMEM_WAIT;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      sel_run: begin
        // first fetch back after a redirect is wrong-path
        if (kill) begin
          ifid_flush = 1'b1;
          kill_nxt   = 1'b0;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      pc_redirect = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!pc_en),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(WD_W)) u_iwd (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (imem_wait),
    .clear (!imem_wait),
    .cnt   (iwd)
  );

  sat_counter #(.W(WD_W)) u_dwd (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dmem_wait),
    .clear (!dmem_wait),
    .cnt   (dwd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if ((imem_wait && (iwd >= WD_LAST))
              || (dmem_wait && (dwd >= WD_LAST))) begin
      err_timeout <= 1'b1;
    end
  end

endmodule
